// File: rtl/i4004_pkg.sv
// i4004_pkg: shared types and constants for the i4004 bus master.
//   phase_e      - bus phase index A1..X3 (A1 = 0)
//   opcode constants for the RAM-relevant instruction subset
//   next_phase() - phase successor, X3 wraps to A1
//   bank_decode()- 2-bit bank number to one-hot CM-RAM select
package i4004_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  localparam logic [3:0] OPR_SRC  = 4'h2;
  localparam logic [3:0] OPR_IO   = 4'hE;
  localparam logic [7:0] OP_DCL   = 8'hFD;
  localparam logic [7:0] OP_HLT   = 8'hFF;
  localparam logic [3:0] BANK_RST = 4'b0001;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_A1:   return PH_A2;
      PH_A2:   return PH_A3;
      PH_A3:   return PH_M1;
      PH_M1:   return PH_M2;
      PH_M2:   return PH_X1;
      PH_X1:   return PH_X2;
      PH_X2:   return PH_X3;
      default: return PH_A1;
    endcase
  endfunction

  function automatic logic [3:0] bank_decode(input logic [1:0] sel);
    logic [3:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/i4004_phase_seq.sv
// i4004_phase_seq: cycle counter and one-hot phase sequencer.
//   sysclk, reset      - clock, asynchronous active-high reset
//   phase[7:0]         - registered one-hot phase, bit0 = A1
//   sync               - registered, high for all of X3
//   cur_phase          - phase of the current cycle
//   nxt_phase          - phase the next cycle will be in
//   last_cycle         - current cycle is the last one of its phase
module i4004_phase_seq
  import i4004_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  output logic [7:0] phase,
  output logic       sync,
  output phase_e     cur_phase,
  output phase_e     nxt_phase,
  output logic       last_cycle
);

  localparam int unsigned    CW       = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        idx_q, idx_d;
  logic [7:0]    phase_q, phase_d;
  logic          sync_q, sync_d;

  // The first edge after reset only arms the sequencer, so that edge opens
  // a full-length A1 instead of shortening it by one cycle.
  always_comb begin
    run_d      = 1'b1;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_cycle = run_q && (cnt_q == CNT_LAST);
    if (run_q) begin
      if (last_cycle) begin
        cnt_d = '0;
        idx_d = next_phase(idx_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    phase_d        = '0;
    phase_d[idx_d] = 1'b1;
    sync_d         = (idx_d == PH_X3);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= PH_A1;
      phase_q <= 8'h01;
      sync_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign phase     = phase_q;
  assign sync      = sync_q;
  assign cur_phase = idx_q;
  assign nxt_phase = idx_d;

endmodule

// File: rtl/i4004_bus_master.sv
// i4004_bus_master: CPU-side master of the MCS-4 multiplexed 4-bit bus.
// Steps the 8-phase instruction cycle, fetches OPR/OPA, drives PC nibbles,
// issues CM-ROM/CM-RAM and executes SRC, DCL and I/O write/read.
//   sysclk, reset        - clock, asynchronous active-high reset
//   data_in / data_out   - bus read value / bus drive value, data_oe = drive
//   phase, sync          - one-hot phase (bit0 = A1), sync high in X3
//   cm_rom, cm_ram[3:0]  - command strobes
//   pc[11:0]             - current fetch address
//   acc_in, src_addr     - accumulator and SRC address sources
//   rd_data, rd_valid    - I/O read capture and its one-cycle strobe
//   halted               - sticky halt flag
// Optional: define I4004_HALT_EN to make 8'hFF halt the PC; otherwise it is
// a NOP and halted is tied low.
module i4004_bus_master
  import i4004_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic [7:0]  phase,
  output logic        sync,
  output logic        cm_rom,
  output logic [3:0]  cm_ram,
  output logic [11:0] pc,
  input  logic [3:0]  acc_in,
  input  logic [7:0]  src_addr,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  output logic        halted
);

  phase_e cur_ph;
  phase_e nxt_ph;
  logic   last_cycle;
  logic   halt_active;

  i4004_phase_seq #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_seq (
    .sysclk     (sysclk),
    .reset      (reset),
    .phase      (phase),
    .sync       (sync),
    .cur_phase  (cur_ph),
    .nxt_phase  (nxt_ph),
    .last_cycle (last_cycle)
  );

  logic [11:0] pc_q,       pc_d;
  logic [3:0]  opr_q,      opr_d;
  logic [3:0]  opa_q,      opa_d;
  logic [3:0]  bank_sel_q, bank_sel_d;
  logic [3:0]  rd_data_q,  rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [3:0]  data_out_q, data_out_d;
  logic        data_oe_q,  data_oe_d;
  logic        cm_rom_q,   cm_rom_d;
  logic [3:0]  cm_ram_q,   cm_ram_d;

  // Execute-phase decode on the held instruction.
  logic q_io_rd, q_dcl;
  assign q_io_rd = (opr_q == OPR_IO) && opa_q[3];
  assign q_dcl   = ({opr_q, opa_q} == OP_DCL);

  // Decode on next-cycle values: OPR/OPA are captured on the same edge that
  // enters M2/X1, and the bus outputs for that edge must already see them.
  logic d_src, d_io_wr, d_io_rd;
  assign d_src   = (opr_d == OPR_SRC) && opa_d[0];
  assign d_io_wr = (opr_d == OPR_IO) && !opa_d[3];
  assign d_io_rd = (opr_d == OPR_IO) && opa_d[3];

`ifdef I4004_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (last_cycle && (cur_ph == PH_X1) && ({opr_q, opa_q} == OP_HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halt_active = halted_q;
`else
  assign halt_active = 1'b0;
`endif

  assign halted = halt_active;

  // Architectural state updates at the closing edge of each phase.
  always_comb begin
    pc_d       = pc_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    bank_sel_d = bank_sel_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (last_cycle) begin
      case (cur_ph)
        PH_M1: opr_d = data_in;
        PH_M2: begin
          opa_d = data_in;
          if (!halt_active) begin
            pc_d = pc_q + 12'd1;
          end
        end
        PH_X2: begin
          if (q_io_rd) begin
            rd_data_d  = data_in;
            rd_valid_d = 1'b1;
          end
        end
        PH_X3: begin
          if (q_dcl) begin
            bank_sel_d = bank_decode(acc_in[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs registered from the phase being entered, so every strobe
  // starts on the first cycle of its phase and drops on the first cycle after.
  always_comb begin
    data_out_d = '0;
    data_oe_d  = 1'b0;
    cm_rom_d   = 1'b0;
    cm_ram_d   = '0;
    case (nxt_ph)
      PH_A1: begin
        data_oe_d  = 1'b1;
        data_out_d = pc_d[3:0];
      end
      PH_A2: begin
        data_oe_d  = 1'b1;
        data_out_d = pc_d[7:4];
      end
      PH_A3: begin
        data_oe_d  = 1'b1;
        data_out_d = pc_d[11:8];
        cm_rom_d   = 1'b1;
        cm_ram_d   = bank_sel_d;
      end
      PH_M1: ;
      PH_M2: begin
        if (opr_d == OPR_IO) begin
          cm_ram_d = bank_sel_d;
        end
      end
      PH_X1: begin
        data_oe_d  = 1'b1;
        data_out_d = opa_d;
      end
      PH_X2: begin
        data_oe_d = 1'b1;
        if (d_src) begin
          data_out_d = src_addr[7:4];
          cm_rom_d   = 1'b1;
          cm_ram_d   = bank_sel_d;
        end else if (d_io_wr) begin
          data_out_d = acc_in;
        end else if (d_io_rd) begin
          data_oe_d = 1'b0;
        end
      end
      default: begin
        data_oe_d = 1'b1;
        if (d_src) begin
          data_out_d = src_addr[3:0];
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      opr_q      <= '0;
      opa_q      <= '0;
      bank_sel_q <= BANK_RST;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      cm_rom_q   <= 1'b0;
      cm_ram_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      bank_sel_q <= bank_sel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      cm_rom_q   <= cm_rom_d;
      cm_ram_q   <= cm_ram_d;
    end
  end

  assign pc       = pc_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign cm_rom   = cm_rom_q;
  assign cm_ram   = cm_ram_q;

endmodule

// File: tb/tb_i4004_bus_master.sv
// Bench for i4004_bus_master: a ROM image plus an instruction-level model
// predicting every bus output on every sysclk of each instruction.
`timescale 1ns/1ps
module tb_i4004_bus_master;

  localparam int unsigned PC_CYC = 2;

  logic        sysclk;
  logic        reset;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_oe;
  logic [7:0]  phase;
  logic        sync;
  logic        cm_rom;
  logic [3:0]  cm_ram;
  logic [11:0] pc;
  logic [3:0]  acc_in;
  logic [7:0]  src_addr;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        halted;

  i4004_bus_master #(
    .PHASE_CYCLES (PC_CYC)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .phase    (phase),
    .sync     (sync),
    .cm_rom   (cm_rom),
    .cm_ram   (cm_ram),
    .pc       (pc),
    .acc_in   (acc_in),
    .src_addr (src_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .halted   (halted)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [7:0]  rom [4096];
  logic [11:0] m_pc;
  logic [3:0]  m_bank;
  logic [3:0]  m_rd;
  logic        m_halt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".phase"},    32'(phase),    32'h01);
    check_eq({tag, ".sync"},     32'(sync),     32'h0);
    check_eq({tag, ".pc"},       32'(pc),       32'h0);
    check_eq({tag, ".data_oe"},  32'(data_oe),  32'h0);
    check_eq({tag, ".data_out"}, 32'(data_out), 32'h0);
    check_eq({tag, ".cm_rom"},   32'(cm_rom),   32'h0);
    check_eq({tag, ".cm_ram"},   32'(cm_ram),   32'h0);
    check_eq({tag, ".rd_data"},  32'(rd_data),  32'h0);
    check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
    check_eq({tag, ".halted"},   32'(halted),   32'h0);
  endtask

  task automatic model_reset();
    m_pc   = 12'h000;
    m_bank = 4'b0001;
    m_rd   = 4'h0;
    m_halt = 1'b0;
  endtask

  // One full instruction; optionally pulls reset on the first X2 cycle.
  task automatic run_instr(input bit inject_reset);
    logic [7:0]  op;
    logic [3:0]  opr, opa, acc, ram_val;
    logic [7:0]  src;
    bit          is_src, io_wr, io_rd, is_dcl, is_hlt, halt_at_start;
    logic [7:0]  e_phase;
    logic [3:0]  e_out, e_ram;
    logic        e_oe, e_rom, e_rdv;
    logic [11:0] e_pc;

    op     = rom[m_pc];
    opr    = op[7:4];
    opa    = op[3:0];
    is_src = (opr == 4'h2) && opa[0];
    io_wr  = (opr == 4'hE) && !opa[3];
    io_rd  = (opr == 4'hE) && opa[3];
    is_dcl = (op == 8'hFD);
`ifdef I4004_HALT_EN
    is_hlt = (op == 8'hFF);
`else
    is_hlt = 1'b0;
`endif
    halt_at_start = m_halt;
    acc     = (m_pc == 12'h002) ? 4'h2  : 4'($urandom);
    src     = (m_pc == 12'h004) ? 8'h5A : 8'($urandom);
    ram_val = (m_pc == 12'h005) ? 4'h7  : 4'($urandom);

    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < int'(PC_CYC); c++) begin
        @(posedge sysclk);
        #1;
        if (ph == 7 && c == 0 && io_rd) m_rd = ram_val;
        if (ph == 6 && c == 0 && is_hlt) m_halt = 1'b1;

        e_phase     = '0;
        e_phase[ph] = 1'b1;
        e_oe  = 1'b1;
        e_out = 4'h0;
        e_rom = 1'b0;
        e_ram = 4'h0;
        e_rdv = (ph == 7 && c == 0 && io_rd);
        e_pc  = (ph >= 5 && !halt_at_start) ? m_pc + 12'd1 : m_pc;
        case (ph)
          0: e_out = m_pc[3:0];
          1: e_out = m_pc[7:4];
          2: begin
            e_out = m_pc[11:8];
            e_rom = 1'b1;
            e_ram = m_bank;
          end
          3: e_oe = 1'b0;
          4: begin
            e_oe  = 1'b0;
            e_ram = (opr == 4'hE) ? m_bank : 4'h0;
          end
          5: e_out = opa;
          6: begin
            if (is_src) begin
              e_out = src[7:4];
              e_rom = 1'b1;
              e_ram = m_bank;
            end else if (io_wr) begin
              e_out = acc;
            end else if (io_rd) begin
              e_oe = 1'b0;
            end
          end
          default: if (is_src) e_out = src[3:0];
        endcase

        check_eq("phase",    32'(phase),    32'(e_phase));
        check_eq("sync",     32'(sync),     32'(ph == 7));
        check_eq("data_oe",  32'(data_oe),  32'(e_oe));
        if (e_oe) check_eq("data_out", 32'(data_out), 32'(e_out));
        check_eq("cm_rom",   32'(cm_rom),   32'(e_rom));
        check_eq("cm_ram",   32'(cm_ram),   32'(e_ram));
        check_eq("pc",       32'(pc),       32'(e_pc));
        check_eq("rd_valid", 32'(rd_valid), 32'(e_rdv));
        check_eq("rd_data",  32'(rd_data),  32'(m_rd));
        check_eq("halted",   32'(halted),   32'(m_halt));

        if (ph == 0 && c == 0) begin
          acc_in   = acc;
          src_addr = src;
        end
        if (ph == 3)                data_in = op[7:4];
        else if (ph == 4)           data_in = op[3:0];
        else if (ph == 6 && io_rd)  data_in = ram_val;
        else                        data_in = 4'($urandom);

        if (inject_reset && ph == 6 && c == 0) begin
          reset = 1'b1;
          #1;
          check_reset_vals("rst_async");
          @(posedge sysclk);
          #1;
          check_reset_vals("rst_edge");
          @(negedge sysclk);
          reset   = 1'b0;
          data_in = 4'h0;
          model_reset();
          return;
        end
      end
    end

    if (is_dcl) m_bank = 4'b0001 << acc[1:0];
    if (!halt_at_start) m_pc = m_pc + 12'd1;
  endtask

  initial begin
    logic [7:0] b;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    data_in  = 4'h0;
    acc_in   = 4'h0;
    src_addr = 8'h00;

    for (int a = 0; a < 4096; a++) begin
      case ($urandom_range(0, 7))
        0, 1:    b = 8'($urandom);
        2:       b = 8'hFD;
        3:       b = {4'hE, 1'b0, 3'($urandom)};
        4:       b = {4'hE, 1'b1, 3'($urandom)};
        5:       b = {4'h2, 4'($urandom)};
        default: b = 8'h00;
      endcase
      if (b == 8'hFF) b = 8'h00;
      rom[a] = b;
    end
    rom[0]       = 8'h00;
    rom[1]       = 8'h00;
    rom[2]       = 8'hFD;
    rom[3]       = 8'hE0;
    rom[4]       = 8'h21;
    rom[5]       = 8'hE9;
    rom[12'hFFF] = 8'hFF;
    model_reset();

    repeat (3) @(posedge sysclk);
    #1;
    check_reset_vals("reset");
    @(negedge sysclk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_instr(1'b0);
    run_instr(1'b1);
    for (int i = 0; i < 4096 + 12; i++) run_instr(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i4004_bus_master.md
# i4004_bus_master

Single-clock i4004 bus sequencer: the CPU-side master of the MCS-4 4-bit multiplexed bus that feeds i4002 RAM and i4001 ROM chips. It steps the 8-phase instruction cycle, drives PC nibbles, fetches OPR/OPA from ROM, and issues CM-ROM/CM-RAM strobes. It executes only the RAM-relevant subset (SRC, DCL, I/O write/read class, optional HLT); all other opcodes are NOPs. It replaces a hand-coded CPU model in RAM/ROM system benches and serves as the bus front-end for a later full CPU.

## Interface
- PHASE_CYCLES, 4, sysclk cycles per bus phase (min 2)
- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- data_in  in  4  bus read value
- data_out  out  4  bus drive value
- data_oe  out  1  1 = master drives bus
- phase  out  8  one-hot {X3,X2,X1,M2,M1,A3,A2,A1}, bit0 = A1
- sync  out  1  high for all of X3
- cm_rom  out  1  ROM command strobe
- cm_ram  out  4  RAM bank command strobes
- pc  out  12  current fetch address
- acc_in  in  4  accumulator value for writes and DCL
- src_addr  in  8  {chip,reg,char} sent by SRC
- rd_data  out  4  value captured in I/O read
- rd_valid  out  1  one-cycle pulse when rd_data updates
- halted  out  1  sticky halt flag (see Configuration)

## Operation
- Phase order A1→A2→A3→M1→M2→X1→X2→X3→A1; each lasts PHASE_CYCLES; internal counter 0..PHASE_CYCLES-1.
- A1/A2/A3: data_out = pc[3:0]/pc[7:4]/pc[11:8], data_oe=1. A3: cm_rom=1 and cm_ram=bank_sel.
- M1: data_oe=0; opr <= data_in on last cycle of M1. M2: data_oe=0; opa <= data_in on last cycle of M2; cm_ram=bank_sel iff opr==4'hE. pc <= pc+1 (mod 4096) on last cycle of M2 unless halted.
- X1: data_out=opa, data_oe=1.
- SRC (opr=2, opa[0]=1): X2 data_out=src_addr[7:4], cm_ram=bank_sel, cm_rom=1; X3 data_out=src_addr[3:0].
- I/O write (opr=E, opa[3]=0): X2 data_out=acc_in, data_oe=1.
- I/O read (opr=E, opa[3]=1): X2 data_oe=0; rd_data <= data_in on last X2 cycle, rd_valid pulses that same edge +1 cycle.
- DCL (8'hFD): at end of X3, bank_sel <= one-hot decode of acc_in[1:0] (00→4'b0001 … 11→4'b1000).
- All other opcodes: X2/X3 data_oe=1, data_out=4'h0; no state change.
- bank_sel drives cm_ram only in the phases above; cm_ram=0 otherwise.

## Timing
- Reset values: phase=A1 (8'h01), counter 0, sync 0, pc 0, opr/opa 0, bank_sel 4'b0001, data_oe 0, data_out 0, cm_rom 0, cm_ram 0, rd_data 0, rd_valid 0, halted 0.
- Reset mid-cycle: all state returns to reset values immediately; first A1 begins on first sysclk edge after reset falls.
- All outputs registered; strobes align exactly with phase boundaries (asserted first cycle of phase, deasserted first cycle after).
- Full instruction cycle = 8*PHASE_CYCLES sysclk.
- PC wrap: 12'hFFF → 12'h000, no flag.

## Configuration
- I4004_HALT_EN defined: 8'hFF sets halted at end of X1; pc freezes, phases/sync continue, bus fetches repeat at frozen pc; cleared only by reset.
- Undefined: 8'hFF is a NOP; halted tied 0.

## Structure
- Package i4004_pkg: phase index enum (A1..X3), opcode constants (OPR_SRC=2, OPR_IO=E, OP_DCL=8'hFD, OP_HLT=8'hFF).
- Sub-module i4004_phase_seq: cycle counter + one-hot phase + sync, with a last_cycle output; top holds PC, OPR/OPA, decode, bus muxing.

## Test plan
- Reset then free-run, PHASE_CYCLES=4, ROM model returns 8'h00 → phase one-hot cycles every 32 clocks, sync high 4 clocks in X3, pc 0,1,2…
- ROM FD with acc_in=2 then E0 → cm_ram=4'b0100 in A3 and M2 of the E0 cycle; data_out=acc_in in X2.
- ROM 21 with src_addr=8'h5A → X2 data_out=5, cm_ram+cm_rom high; X3 data_out=A.
- ROM E9, RAM model drives 4'h7 in X2 → rd_data=7, rd_valid single pulse, data_oe=0 in X2.
- Preload pc to 12'hFFF via fetches → next pc 12'h000; reset asserted during X2 → outputs at reset values next edge, restart at A1.
- With I4004_HALT_EN, ROM FF → halted=1, pc frozen, sync continues; without it pc keeps incrementing.
